signal_sensor_frontend: RTL and testbench

Input-side front end for the traffic-signal controller. Conditions the three raw vehicle-detector lines (westbound highway, eastbound highway, country road) into the clean, registered `W`, `E`, `C` levels the signal state machine consumes. Uses the controller's light outputs `HL`/`CL` as feedback to latch and clear the country-road request. Sits between the detector pads and the controller, on the controller's clock.

---
 rtl/signal_sensor_frontend_if.sv | 27 ++
 rtl/signal_sensor_frontend.sv | 161 ++++++++++++++++
 tb/tb_signal_sensor_frontend.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/signal_sensor_frontend_if.sv
// Detector/feedback bundle between pads, sensor front end and signal controller.
// Latency: none (wires only).
// Backpressure: none; level signals with no flow control.
interface signal_sensor_frontend_if;
  logic       W_RAW;
  logic       E_RAW;
  logic       C_RAW;
  logic       HL;
  logic       CL;
  logic       W;
  logic       E;
  logic       C;
  logic [7:0] SVC_CNT;
  logic       ERR;

  // Driver side: detector pads plus controller light feedback.
  modport master (
    output W_RAW, E_RAW, C_RAW, HL, CL,
    input  W, E, C, SVC_CNT, ERR
  );

  // Front-end side: consumes raw lines and feedback, produces clean levels.
  modport slave (
    input  W_RAW, E_RAW, C_RAW, HL, CL,
    output W, E, C, SVC_CNT, ERR
  );
endinterface

// File: rtl/signal_sensor_frontend.sv
// Conditions W/E/C detector lines (sync + debounce) and latches the country request; SENSOR_LATCH_EN builds the latch FSM.
// Latency: a held raw change shows at edge DEB_CYCLES+2 after first sample; latched C one edge later.
// Backpressure: none; levels are sampled every cycle and HL/CL are read-only feedback.
module signal_sensor_frontend #(
  parameter int DEB_CYCLES   = 4,
  parameter int SERVE_CYCLES = 3
) (
  input  logic                     CLK,
  input  logic                     RST,
  signal_sensor_frontend_if.slave  bus
);

  localparam int            DW       = $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  // Parameter sanity: both counts must be at least one cycle.
  if (DEB_CYCLES < 1 || SERVE_CYCLES < 1) begin : g_bad_param
    $error("signal_sensor_frontend: DEB_CYCLES and SERVE_CYCLES must be >= 1");
  end

  // Lane order: 0 = westbound, 1 = eastbound, 2 = country road.
  logic [2:0]    raw;
  logic [2:0]    sync1_q;
  logic [2:0]    sync2_q;
  logic [2:0]    stable_q;
  logic [2:0]    stable_d;
  logic [DW-1:0] deb_cnt_q [3];
  logic [DW-1:0] deb_cnt_d [3];
  logic          err_q;
  logic          err_d;

  assign raw = {bus.C_RAW, bus.E_RAW, bus.W_RAW};

  // Debounce: count consecutive samples that disagree with the accepted level.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 3; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Two-flop synchronizers, accepted levels and debounce counters.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
    end
  end

  // Both greens at once is a controller fault; remember it until reset.
  assign err_d = err_q | (bus.HL & bus.CL);

  // Sticky conflict flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.W   = stable_q[0];
  assign bus.E   = stable_q[1];
  assign bus.ERR = err_q;

`ifdef SENSOR_LATCH_EN
  localparam int            SW         = $clog2(SERVE_CYCLES + 1);
  localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_SERVED = 2'd2;

  logic          dc;
  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [SW-1:0] serve_cnt_q;
  logic [SW-1:0] serve_cnt_d;
  logic [7:0]    svc_cnt_q;
  logic [7:0]    svc_cnt_d;

  assign dc = stable_q[2];

  // Request latch: hold C until the country green has been on long enough,
  // then re-arm only after the light goes red with a vehicle still present.
  always_comb begin
    state_d     = state_q;
    serve_cnt_d = '0;
    svc_cnt_d   = svc_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (dc) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // A falling dc does not cancel a pending request; only service does.
        if (bus.CL) begin
          if (serve_cnt_q == SERVE_LAST) begin
            state_d = ST_SERVED;
            if (svc_cnt_q != 8'hFF) begin
              svc_cnt_d = svc_cnt_q + 8'd1;
            end
          end else begin
            serve_cnt_d = serve_cnt_q + SW'(1);
          end
        end
      end
      ST_SERVED: begin
        if (!dc) begin
          state_d = ST_IDLE;
        end else if (!bus.CL) begin
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request FSM, serve counter and completed-service counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      serve_cnt_q <= '0;
      svc_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      serve_cnt_q <= serve_cnt_d;
      svc_cnt_q   <= svc_cnt_d;
    end
  end

  assign bus.C       = (state_q == ST_REQ);
  assign bus.SVC_CNT = svc_cnt_q;
`else
  // Plain level mode: the debounced country line is the request.
  assign bus.C       = stable_q[2];
  assign bus.SVC_CNT = 8'd0;
`endif

endmodule

// File: tb/tb_signal_sensor_frontend.sv
// Directed bench for signal_sensor_frontend (DEB_CYCLES=4, SERVE_CYCLES=3).
// Inputs change 1ns after a rising edge; outputs are sampled there too.
// Covers both builds via SENSOR_LATCH_EN.
module tb_signal_sensor_frontend;

`ifdef SENSOR_LATCH_EN
  localparam int C_EDGE = 7;
`else
  localparam int C_EDGE = 6;
`endif

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  signal_sensor_frontend_if bus ();

  signal_sensor_frontend #(
    .DEB_CYCLES   (4),
    .SERVE_CYCLES (3)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic w_raw;
    logic e_raw;
    logic c_raw;
    logic hl;
    logic cl;
    logic exp_w;
    logic exp_e;
    logic exp_c;
    logic exp_err;
  } vec_t;

  vec_t vecs [18];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic w, input logic e, input logic c, input logic hl, input logic cl);
    bus.W_RAW = w;
    bus.E_RAW = e;
    bus.C_RAW = c;
    bus.HL    = hl;
    bus.CL    = cl;
  endtask

  task automatic setv(input int i, input logic e_raw, input logic hl,
                      input logic ew, input logic ee);
    vecs[i].w_raw   = 1'b1;
    vecs[i].e_raw   = e_raw;
    vecs[i].c_raw   = 1'b1;
    vecs[i].hl      = hl;
    vecs[i].cl      = 1'b0;
    vecs[i].exp_w   = ew;
    vecs[i].exp_e   = ee;
    vecs[i].exp_c   = ((i + 1) >= C_EDGE);
    vecs[i].exp_err = 1'b0;
  endtask

  initial begin
    // Row i drives the inputs sampled on edge i+1 and holds the outputs after it.
    // W held from edge 1; E pulses 3 cycles (rejected), then held 4 cycles
    // from edge 9 (rises at 14, falls at 18); C held from edge 1.
    setv( 0, 1'b1, 1'b0, 1'b0, 1'b0);
    setv( 1, 1'b1, 1'b0, 1'b0, 1'b0);
    setv( 2, 1'b1, 1'b0, 1'b0, 1'b0);
    setv( 3, 1'b0, 1'b0, 1'b0, 1'b0);
    setv( 4, 1'b0, 1'b0, 1'b0, 1'b0);
    setv( 5, 1'b0, 1'b0, 1'b1, 1'b0);
    setv( 6, 1'b0, 1'b0, 1'b1, 1'b0);
    setv( 7, 1'b0, 1'b0, 1'b1, 1'b0);
    setv( 8, 1'b1, 1'b0, 1'b1, 1'b0);
    setv( 9, 1'b1, 1'b1, 1'b1, 1'b0);
    setv(10, 1'b1, 1'b1, 1'b1, 1'b0);
    setv(11, 1'b1, 1'b1, 1'b1, 1'b0);
    setv(12, 1'b0, 1'b0, 1'b1, 1'b0);
    setv(13, 1'b0, 1'b0, 1'b1, 1'b1);
    setv(14, 1'b0, 1'b0, 1'b1, 1'b1);
    setv(15, 1'b0, 1'b0, 1'b1, 1'b1);
    setv(16, 1'b0, 1'b0, 1'b1, 1'b1);
    setv(17, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset state.
    RST = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    check("reset_W",   {31'd0, bus.W},   32'd0);
    check("reset_E",   {31'd0, bus.E},   32'd0);
    check("reset_C",   {31'd0, bus.C},   32'd0);
    check("reset_SVC", {24'd0, bus.SVC_CNT}, 32'd0);
    check("reset_ERR", {31'd0, bus.ERR}, 32'd0);
    RST = 1'b0;

    // Table-driven debounce vectors.
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].w_raw, vecs[i].e_raw, vecs[i].c_raw, vecs[i].hl, vecs[i].cl);
      step();
      check($sformatf("vec%0d_W", i + 1),   {31'd0, bus.W},   {31'd0, vecs[i].exp_w});
      check($sformatf("vec%0d_E", i + 1),   {31'd0, bus.E},   {31'd0, vecs[i].exp_e});
      check($sformatf("vec%0d_C", i + 1),   {31'd0, bus.C},   {31'd0, vecs[i].exp_c});
      check($sformatf("vec%0d_ERR", i + 1), {31'd0, bus.ERR}, {31'd0, vecs[i].exp_err});
      check($sformatf("vec%0d_SVC", i + 1), {24'd0, bus.SVC_CNT}, 32'd0);
    end

`ifdef SENSOR_LATCH_EN
    // Service: CL 1,1,0,1,1,1 -> C falls on the third consecutive CL=1.
    bus.CL = 1'b1; step(); check("serve_a1_C", {31'd0, bus.C}, 32'd1);
    bus.CL = 1'b1; step(); check("serve_a2_C", {31'd0, bus.C}, 32'd1);
    bus.CL = 1'b0; step(); check("serve_gap_C", {31'd0, bus.C}, 32'd1);
    bus.CL = 1'b1; step(); check("serve_b1_C", {31'd0, bus.C}, 32'd1);
    bus.CL = 1'b1; step(); check("serve_b2_C", {31'd0, bus.C}, 32'd1);
    check("serve_b2_SVC", {24'd0, bus.SVC_CNT}, 32'd0);
    bus.CL = 1'b1; step(); check("served_C", {31'd0, bus.C}, 32'd0);
    check("served_SVC", {24'd0, bus.SVC_CNT}, 32'd1);
    bus.CL = 1'b1; step(); check("served_hold_C", {31'd0, bus.C}, 32'd0);
    check("served_hold_SVC", {24'd0, bus.SVC_CNT}, 32'd1);
    bus.CL = 1'b0; step(); check("rereq_C", {31'd0, bus.C}, 32'd1);

    // 260 further services: counter saturates at 255.
    for (int k = 0; k < 260; k++) begin
      bus.CL = 1'b1;
      step(); step(); step();
      if (k == 252) check("svc_254", {24'd0, bus.SVC_CNT}, 32'd254);
      bus.CL = 1'b0;
      step();
    end
    check("svc_sat", {24'd0, bus.SVC_CNT}, 32'd255);
    check("svc_sat_C", {31'd0, bus.C}, 32'd1);

    // Vehicle leaves while requested: request stays latched until served,
    // then SERVED with dc=0 returns to IDLE.
    bus.C_RAW = 1'b0;
    repeat (8) step();
    check("latched_C", {31'd0, bus.C}, 32'd1);
    bus.CL = 1'b1;
    step(); step(); step();
    check("gone_served_C", {31'd0, bus.C}, 32'd0);
    check("gone_svc_sat", {24'd0, bus.SVC_CNT}, 32'd255);
    bus.CL = 1'b0;
    step(); step();
    check("idle_C", {31'd0, bus.C}, 32'd0);
`else
    // Level mode: CL activity neither clears C nor counts services.
    bus.CL = 1'b1;
    step(); step(); step();
    check("level_C_cl", {31'd0, bus.C}, 32'd1);
    check("level_SVC", {24'd0, bus.SVC_CNT}, 32'd0);
    bus.CL = 1'b0;
    bus.C_RAW = 1'b0;
    repeat (5) step();
    check("level_C_e5", {31'd0, bus.C}, 32'd1);
    step();
    check("level_C_e6", {31'd0, bus.C}, 32'd0);
`endif

    // Conflicting greens for one cycle: ERR sets and stays.
    check("err_before", {31'd0, bus.ERR}, 32'd0);
    bus.HL = 1'b1;
    bus.CL = 1'b1;
    step();
    check("err_set", {31'd0, bus.ERR}, 32'd1);
    bus.HL = 1'b0;
    bus.CL = 1'b0;
    step(); step(); step();
    check("err_sticky", {31'd0, bus.ERR}, 32'd1);

    // Reach REQ (latch build) / C high, then E mid-debounce, then reset.
    bus.C_RAW = 1'b1;
    repeat (7) step();
    check("pre_rst_C", {31'd0, bus.C}, 32'd1);
    bus.E_RAW = 1'b1;
    step(); step();
    RST = 1'b1;
    #1;
    check("rst_W",   {31'd0, bus.W},   32'd0);
    check("rst_E",   {31'd0, bus.E},   32'd0);
    check("rst_C",   {31'd0, bus.C},   32'd0);
    check("rst_SVC", {24'd0, bus.SVC_CNT}, 32'd0);
    check("rst_ERR", {31'd0, bus.ERR}, 32'd0);
    step(); step();
    bus.E_RAW = 1'b0;
    RST = 1'b0;

    // Lines still high after reset are re-qualified from scratch.
    for (int n = 1; n <= 7; n++) begin
      step();
      check($sformatf("requal%0d_W", n), {31'd0, bus.W}, (n >= 6) ? 32'd1 : 32'd0);
      check($sformatf("requal%0d_C", n), {31'd0, bus.C}, (n >= C_EDGE) ? 32'd1 : 32'd0);
    end
    check("requal_ERR", {31'd0, bus.ERR}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
